// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM state encoding and the queued
// {address, instruction} entry.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  addr;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-to-decode handshake: head-of-queue instruction with its address,
// qualified by instr_valid and accepted by instr_ready.
interface pc_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 24
);
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  pc_out;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output instr_out,
    output pc_out,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr_out,
    input  pc_out,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small FIFO of fetch entries with flush. The head is registered so it holds
// its last value while the queue is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     head_q, head_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // The new head is the entry being written only when it lands in an empty queue.
    if (count_d != '0) begin
      if (do_push && !flush_i && (rd_ptr_d == wr_ptr_q)) begin
        head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign rdata_o = head_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the pc, reads instruction memory combinationally, queues
// {pc, Instr} for decode, and gates fetching with an IDLE/RUN/HALTED FSM.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter bit                WRAP_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [1:0]         state,
  output logic [15:0]        fetch_count,
  pc_fetch_unit_if.master    dec_if
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              push, pop, last_pc;
  logic              fifo_full, fifo_empty;
  fetch_entry_t      wentry, head;

  assign pop     = !fifo_empty && dec_if.instr_ready;
  assign push    = (state_q == RUN) && !redirect && (!fifo_full || pop);
  assign last_pc = !WRAP_EN && (pc_q == '1);

  always_comb begin
    wentry       = '0;
    wentry.addr  = pc_q;
    wentry.instr = Instr;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fcnt_d  = fcnt_q;

    if (redirect) begin
      pc_d = redirect_target;
    end else if (push && !last_pc) begin
      pc_d = pc_q + 1'b1;
    end

    if (push) begin
      fcnt_d = fcnt_q + 16'd1;
    end

    case (state_q)
      IDLE, HALTED: if (start) state_d = RUN;
      RUN:          if (push && last_pc) state_d = HALTED;
      default:      state_d = IDLE;
    endcase

    // halt overrides start and applies alongside a redirect.
    if (halt) begin
      state_d = HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pc                 = pc_q;
  assign state              = state_q;
  assign fetch_count        = fcnt_q;
  assign dec_if.instr_out   = head.instr;
  assign dec_if.pc_out      = head.addr;
  assign dec_if.instr_valid = !fifo_empty;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised bench for pc_fetch_unit: a WRAP_EN=1 and a WRAP_EN=0 instance
// share stimulus; a reference model feeds scoreboards read by a monitor.
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_target = 8'h00;
  logic       instr_ready = 1'b0;

  logic [7:0]  pc0, pc1;
  logic [23:0] imem0, imem1;
  logic [1:0]  st0, st1;
  logic [15:0] fc0, fc1;

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.ADDR_W(8), .INSTR_W(24)) if0 ();
  pc_fetch_unit_if #(.ADDR_W(8), .INSTR_W(24)) if1 ();

  assign if0.instr_ready = instr_ready;
  assign if1.instr_ready = instr_ready;
  assign imem0 = {16'hA5A5, pc0};
  assign imem1 = {16'hA5A5, pc1};

  pc_fetch_unit #(.DEPTH(2), .RESET_PC(8'h00), .WRAP_EN(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .pc(pc0), .Instr(imem0),
    .redirect(redirect), .redirect_target(redirect_target), .state(st0),
    .fetch_count(fc0), .dec_if(if0)
  );

  pc_fetch_unit #(.DEPTH(2), .RESET_PC(8'h00), .WRAP_EN(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .pc(pc1), .Instr(imem1),
    .redirect(redirect), .redirect_target(redirect_target), .state(st1),
    .fetch_count(fc1), .dec_if(if1)
  );

  // Reference model state: what the fetch stage should look like after each edge.
  typedef struct packed {
    logic [7:0]  pc;
    logic [1:0]  st;
    logic [2:0]  cnt;
    logic [15:0] fc;
    logic        fresh;
  } mdl_t;

  mdl_t m0 = '0;
  mdl_t m1 = '0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  function automatic bit will_push(input mdl_t m);
    return (m.st == 2'd1) && !redirect &&
           ((m.cnt < 3'd2) || ((m.cnt != 3'd0) && instr_ready));
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit wrap);
    mdl_t r;
    bit   p, pp, hit_end;
    r = m;
    if (reset) begin
      r = '0;
      r.fresh = 1'b1;
      return r;
    end
    p  = will_push(m);
    pp = (m.cnt != 3'd0) && instr_ready;
    hit_end = p && !wrap && (m.pc == 8'd255);
    if (redirect) begin
      r.cnt = 3'd0;
      r.pc  = redirect_target;
    end else begin
      if (pp) r.cnt = r.cnt - 3'd1;
      if (p) begin
        r.cnt   = r.cnt + 3'd1;
        r.fc    = m.fc + 16'd1;
        r.fresh = 1'b0;
        if (!hit_end) r.pc = 8'((int'(m.pc) + 1) % 256);
      end
    end
    if (halt) r.st = 2'd2;
    else if ((m.st != 2'd1) && start) r.st = 2'd1;
    else if (hit_end) r.st = 2'd2;
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset || redirect) begin
      exp0.delete();
      exp1.delete();
    end else begin
      if (will_push(m0)) exp0.push_back({m0.pc, 16'hA5A5, m0.pc});
      if (will_push(m1)) exp1.push_back({m1.pc, 16'hA5A5, m1.pc});
    end
    m0    <= step(m0, 1'b1);
    m1    <= step(m1, 1'b0);
    armed <= armed | reset;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: sample between edges; a handshake pops the scoreboard.
  always @(negedge clk) begin
    if (armed) begin
      chk("pc0", 32'(pc0), 32'(m0.pc));
      chk("state0", 32'(st0), 32'(m0.st));
      chk("fetch_count0", 32'(fc0), 32'(m0.fc));
      chk("valid0", 32'(if0.instr_valid), 32'(m0.cnt != 3'd0));
      if (m0.fresh) chk("reset_head0", {if0.pc_out, if0.instr_out}, 32'h0);
      if (if0.instr_valid && instr_ready && !redirect && !reset) begin
        if (exp0.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL head0: got %h, expected no entry at %0t",
                   {if0.pc_out, if0.instr_out}, $time);
        end else begin
          chk("head0", {if0.pc_out, if0.instr_out}, exp0.pop_front());
        end
      end

      chk("pc1", 32'(pc1), 32'(m1.pc));
      chk("state1", 32'(st1), 32'(m1.st));
      chk("fetch_count1", 32'(fc1), 32'(m1.fc));
      chk("valid1", 32'(if1.instr_valid), 32'(m1.cnt != 3'd0));
      if (m1.fresh) chk("reset_head1", {if1.pc_out, if1.instr_out}, 32'h0);
      if (if1.instr_valid && instr_ready && !redirect && !reset) begin
        if (exp1.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL head1: got %h, expected no entry at %0t",
                   {if1.pc_out, if1.instr_out}, $time);
        end else begin
          chk("head1", {if1.pc_out, if1.instr_out}, exp1.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    tick(3);
    reset = 1'b0;

    // Basic stream: start with decode always ready.
    start = 1'b1; instr_ready = 1'b1; tick();
    start = 1'b0; tick(6);

    // Backpressure from a fresh start: queue fills, pc stalls at 02.
    reset = 1'b1; tick();
    reset = 1'b0; start = 1'b1; instr_ready = 1'b0; tick();
    start = 1'b0; tick(5);
    instr_ready = 1'b1; tick(4);

    // Redirect while the queue holds entries.
    instr_ready = 1'b0; tick(3);
    redirect = 1'b1; redirect_target = 8'h40; tick();
    redirect = 1'b0; instr_ready = 1'b1; tick(4);

    // Run across the top of the address space.
    redirect = 1'b1; redirect_target = 8'hFE; tick();
    redirect = 1'b0; tick(6);

    // Halt mid-run, drain, then resume.
    halt = 1'b1; tick();
    halt = 1'b0; tick(4);
    start = 1'b1; tick();
    start = 1'b0; tick(3);

    // Reset while full and running, then redirect together with halt.
    instr_ready = 1'b0; tick(4);
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    redirect = 1'b1; halt = 1'b1; redirect_target = 8'h33; tick();
    redirect = 1'b0; halt = 1'b0; tick(3);
    start = 1'b1; halt = 1'b1; tick();
    start = 1'b0; halt = 1'b0; tick(2);

    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 199) == 0);
      start           = ($urandom_range(0, 4) == 0);
      halt            = ($urandom_range(0, 24) == 0);
      redirect        = ($urandom_range(0, 19) == 0);
      redirect_target = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3))
                                                    : 8'($urandom_range(0, 255));
      instr_ready     = ($urandom_range(0, 9) < 7);
      tick();
    end

    reset = 1'b0; start = 1'b0; halt = 1'b1; redirect = 1'b0; instr_ready = 1'b1;
    tick();
    halt = 1'b0; tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Fetch stage directly upstream of instruction_memory. It owns the program counter and drives `pc` to the asynchronous-read instruction memory. It captures the returned 24-bit `Instr` together with its address into a small fetch queue, and hands entries to decode over a valid/ready handshake. Branch/jump redirects flush the queue; a run/halt state machine gates fetching.

Parameters:
ADDR_W, 8, width of pc / instruction address (word-addressed, +1 per instruction)
INSTR_W, 24, instruction width
DEPTH, 2, fetch queue entries (power of two, >=2)
RESET_PC, 8'h00, pc value after reset
WRAP_EN, 1, 1: pc wraps 8'hFF->8'h00; 0: halt after fetching 8'hFF

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  leave IDLE/HALTED and begin fetching at current pc
halt  in  1  stop fetching (queue still drains)
pc  out  ADDR_W  address to instruction_memory
Instr  in  INSTR_W  instruction_memory data, combinational from pc, same cycle
redirect  in  1  branch/jump taken: flush and load redirect_target
redirect_target  in  ADDR_W  new pc
instr_out  out  INSTR_W  head-of-queue instruction
pc_out  out  ADDR_W  address of instr_out
instr_valid  out  1  queue non-empty
instr_ready  in  1  decode accepts head this cycle
state  out  2  fetch_state_t encoding
fetch_count  out  16  number of pushes since reset, wraps at 16'hFFFF

Behaviour:
- Reset (sync, priority over everything): pc=RESET_PC, queue empty, instr_valid=0, instr_out=0, pc_out=0, state=IDLE, fetch_count=0. In-flight entries are discarded.
- States: IDLE(0), RUN(1), HALTED(2).
  - IDLE/HALTED --start--> RUN.
  - RUN --halt--> HALTED.
  - RUN --(WRAP_EN=0 and push at pc=8'hFF)--> HALTED, with pc held at 8'hFF.
  - halt and start in the same cycle: halt wins.
- Push condition: state==RUN && !redirect && (count<DEPTH || pop). On push:
  - enqueue {pc, Instr};
  - pc<=pc+1, modulo 2^ADDR_W when WRAP_EN=1;
  - fetch_count++.
- Pop: instr_valid && instr_ready. The head advances at the clock edge.
- Latency: start sampled at edge E0 -> RUN; pc presented during the following cycle; pushed at E1; instr_valid=1 after E1 with instr_out=imem[pc]. One cycle from pc to instr_valid.
- Full with no pop: no push, pc holds. Full with pop in the same cycle: push and pop both occur; count unchanged.
- Empty: instr_valid=0. instr_out/pc_out hold their last values; they are don't-care to consumers.
- Redirect (any state):
  - queue flushed (count=0), pc<=redirect_target, no push that cycle;
  - instr_valid=0 the next cycle;
  - a simultaneous pop is discarded by the flush.
  - In RUN, the first target instruction is valid one cycle after the redirect cycle.
  - In IDLE/HALTED, only pc is updated.
- Redirect + halt in the same cycle: both apply (flush, load target, go HALTED).
- Queue ordering is strictly FIFO. pc_out always matches the address of the instruction it accompanies.

Decomposition:
- fetch_pkg:
  - fetch_state_t enum {IDLE=2'd0, RUN=2'd1, HALTED=2'd2};
  - ADDR_W/INSTR_W defaults;
  - fetch_entry_t packed struct {addr, instr}.
- Sub-module fetch_fifo: parameterised DEPTH of fetch_entry_t, with push/pop/flush, count, full/empty, and a sync reset.
- pc_fetch_unit holds the pc, FSM and fetch_count, and instantiates fetch_fifo.

Test Plan:
- Reset then start, instr_ready=1, memory model imem[a]={16'hA5A5,a} -> instr_valid rises 1 cycle after RUN; sequence pc_out 00,01,02,03 with instr_out A5A500..A5A503, one per cycle.
- instr_ready=0 for 5 cycles after start -> queue fills at 2 entries; pc stalls at 8'h02; on release, entries 00,01,02 are delivered in order with no gap or duplicate.
- With the queue holding 03,04, assert redirect with target 8'h40 -> next cycle instr_valid=0; following cycle pc_out=40, instr_out=A5A540; entries 03/04 are never seen.
- WRAP_EN=1, redirect to 8'hFE -> pc_out FE,FF,00,01. With WRAP_EN=0 -> FE,FF then state=HALTED, pc=8'hFF, queue drains.
- Halt mid-run at pc=8'h05 -> state=HALTED; already-queued entries drain; no new pushes; start resumes fetching at 8'h05.
- Assert reset while full and RUN -> after the edge: instr_valid=0, pc=00, state=IDLE, fetch_count=0; redirect+halt in the same cycle -> HALTED with pc=target.
